// File: rtl/week6_ex1_truth_table_checker.sv
// Exhaustive truth-table sweep engine: walks every input vector of a small
// combinational circuit, waits SETTLE cycles per vector and counts matches.
module week6_ex1_truth_table_checker #(
  parameter int N_IN   = 7,
  parameter int SETTLE = 2,
  parameter int CNT_W  = N_IN + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(1<<N_IN)-1:0]   exp_table,
  input  logic                   dut_y,
  output logic [N_IN-1:0]        stim,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       fail_cnt,
  output logic [N_IN-1:0]        first_fail_vec,
  output logic                   first_fail_valid,
  output logic                   all_pass,
  output logic [1:0]             state_dbg
);

  localparam int              SC_W     = $clog2(SETTLE) + 1;
  localparam logic [SC_W-1:0] SC_LOAD  = SC_W'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [N_IN-1:0]   ff_vec_q, ff_vec_d;
  logic              ff_valid_q, ff_valid_d;
  logic              exp_bit;
  logic              match;

  assign exp_bit = exp_table[stim_q];
  // Case equality so an unknown circuit output is scored as a mismatch.
  assign match   = (dut_y === exp_bit);

  always_comb begin
    state_d    = state_q;
    sc_d       = sc_q;
    stim_d     = stim_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    ff_vec_d   = ff_vec_q;
    ff_valid_d = ff_valid_q;
    if (abort) begin
      state_d = S_IDLE;
      stim_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            stim_d     = '0;
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            ff_vec_d   = '0;
            ff_valid_d = 1'b0;
            sc_d       = SC_LOAD;
            state_d    = (SETTLE == 1) ? S_CHECK : S_SETTLE;
          end
        end
        S_SETTLE: begin
          sc_d = sc_q - SC_W'(1);
          if (sc_q == SC_W'(1)) state_d = S_CHECK;
        end
        S_CHECK: begin
          if (match) begin
            pass_cnt_d = pass_cnt_q + CNT_W'(1);
          end else begin
            fail_cnt_d = fail_cnt_q + CNT_W'(1);
            if (!ff_valid_q) begin
              ff_vec_d   = stim_q;
              ff_valid_d = 1'b1;
            end
          end
          if (stim_q == LAST_VEC) begin
            stim_d  = '0;
            state_d = S_DONE;
          end else begin
            stim_d  = stim_q + N_IN'(1);
            sc_d    = SC_LOAD;
            state_d = (SETTLE == 1) ? S_CHECK : S_SETTLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sc_q       <= '0;
      stim_q     <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      ff_vec_q   <= '0;
      ff_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sc_q       <= sc_d;
      stim_q     <= stim_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      ff_vec_q   <= ff_vec_d;
      ff_valid_q <= ff_valid_d;
    end
  end

  assign stim             = stim_q;
  assign busy             = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done             = (state_q == S_DONE);
  assign pass_cnt         = pass_cnt_q;
  assign fail_cnt         = fail_cnt_q;
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_valid = ff_valid_q;
  assign all_pass         = done && (fail_cnt_q == '0);
  assign state_dbg        = state_q;

endmodule

// File: doc/week6_ex1_truth_table_checker.md
# week6_ex1_truth_table_checker

Parametrised, self-checking sweep engine for N-input, single-output combinational exercise circuits. It drives every input vector 0..2^N_IN−1 in ascending order onto the circuit under test and waits a programmable settle time. It then samples the circuit output, compares it with an expected truth table and accumulates pass and fail counts, recording the first failing vector. It sits beside a combinational exercise block in synthesis and simulation and replaces hand-picked stimulus with exhaustive, counted checking.

## Interface
- `N_IN`, 7, number of circuit inputs (1..12)
- `SETTLE`, 2, cycles each vector is held before sampling (≥1)
- `CNT_W`, N_IN+1, counter width; holds 2^N_IN without wrap
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: begin a sweep; sampled in IDLE and DONE only
- `abort` in 1: terminate the sweep and return to IDLE; has priority over `start`
- `exp_table` in 2^N_IN: expected output; bit k = expected Y for vector k; must be stable while `busy`
- `dut_y` in 1: output of the circuit under test
- `stim` out N_IN: vector driven to the circuit; bit 0 = first input (A)
- `busy` out 1: sweep in progress
- `done` out 1: sweep complete; level, held in DONE
- `pass_cnt` out CNT_W: matching vectors
- `fail_cnt` out CNT_W: mismatching vectors
- `first_fail_vec` out N_IN: lowest failing vector
- `first_fail_valid` out 1: `first_fail_vec` is meaningful
- `all_pass` out 1: `done` && `fail_cnt`==0

## Operation
- States: IDLE, SETTLE, CHECK, DONE. Internal settle counter is width clog2(SETTLE)+1.
- IDLE or DONE with `start`=1 at an edge:
  - clear `stim`, `pass_cnt`, `fail_cnt`, `first_fail_*` and `done`; set `busy`.
  - Go to SETTLE with the counter loaded to SETTLE−1. If SETTLE=1, go straight to CHECK.
- SETTLE: decrement the counter each cycle. Move to CHECK when the counter reaches 1.
- CHECK: at the edge leaving CHECK, compare `dut_y` with `exp_table[stim]`.
  - Match: `pass_cnt`+1.
  - Mismatch: `fail_cnt`+1. If `first_fail_valid`=0, also capture `stim` and set `first_fail_valid`.
  - If `stim`≠2^N_IN−1: `stim`+1 and reload SETTLE, or stay in CHECK when SETTLE=1.
  - If `stim`=2^N_IN−1: go to DONE with `busy`=0 and `done`=1. `stim` returns to 0.
- DONE: outputs hold until `start` or `abort`. Holding `start` high re-triggers one new sweep per completion and never restarts a sweep that is running.
- `start` while `busy` is ignored.
- `abort` in any state, same edge: go to IDLE with `busy`=0, `done`=0 and `stim`=0. Counters and `first_fail_*` keep the values they had before that edge. The comparison in that cycle is discarded.
- `abort`=1 together with `start`=1: the engine ends in IDLE and no sweep starts.
- Counters cannot overflow: at DONE, `pass_cnt`+`fail_cnt`=2^N_IN exactly.
- X or Z on `dut_y` counts as a mismatch.

## Timing
- Reset value of every output is 0, with `stim`=0, and the state is IDLE. Reset asserted mid-sweep takes effect immediately and asynchronously.
- Start sampled at edge E0: `stim`=0 and `busy`=1 after E0.
- Vector k is driven from edge E0+k·SETTLE and sampled at edge E0+(k+1)·SETTLE.
- `done` rises after edge E0+2^N_IN·SETTLE. Total latency is 2^N_IN·SETTLE cycles. `busy` and `done` are never high together.
- Counters update at the sampling edge, so each count is visible one cycle after the vector's last driven cycle.
- The circuit under test must settle within SETTLE−1 cycles plus combinational delay.

## Test plan
- Reset, then release `rst_n` with no `start` → every output 0 and `stim`=0 for 20 cycles.
- N_IN=3, SETTLE=1, DUT=XOR of `stim` bits, `exp_table`=8'h96 → `done` 8 cycles after start, `pass_cnt`=8, `fail_cnt`=0, `all_pass`=1.
- Same setup, `exp_table`=8'hB6 (bit 5 flipped) → `pass_cnt`=7, `fail_cnt`=1, `first_fail_vec`=3'd5, `first_fail_valid`=1, `all_pass`=0.
- Default N_IN=7, SETTLE=2, DUT and `exp_table` built from the same 7-input function → `pass_cnt`=128, `done` exactly 256 cycles after start, `stim` walks 0..127, each value held 2 cycles.
- N_IN=3, SETTLE=2: `abort` at the edge sampling vector 3 → `busy`=0, `done`=0, `pass_cnt`=3. `start` asserted for 1 cycle while busy → no effect. A new `start` → counters clear and a full sweep yields `pass_cnt`=8.
- Deassert `rst_n` mid-sweep (vector 4) → all outputs 0 immediately. After release the engine is in IDLE and a subsequent `start` completes normally.
